sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : sdram_arbiter
//  Brief    : Round-robin arbiter sharing one SDRAM controller port between
//             two requesters, with read-data capture and read timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int FPGA_ADDR_WIDTH = 23,
    parameter int FPGA_DATA_WIDTH = 32,
    parameter int RD_TIMEOUT      = 255
) (
    input  logic                       fpga_clk,
    input  logic                       fpga_reset,
    input  logic                       m0_req,
    input  logic                       m0_wr_en,
    input  logic [FPGA_ADDR_WIDTH-1:0] m0_addr,
    input  logic [FPGA_DATA_WIDTH-1:0] m0_wr_data,
    output logic                       m0_done,
    output logic [FPGA_DATA_WIDTH-1:0] m0_rd_data,
    output logic                       m0_err,
    input  logic                       m1_req,
    input  logic                       m1_wr_en,
    input  logic [FPGA_ADDR_WIDTH-1:0] m1_addr,
    input  logic [FPGA_DATA_WIDTH-1:0] m1_wr_data,
    output logic                       m1_done,
    output logic [FPGA_DATA_WIDTH-1:0] m1_rd_data,
    output logic                       m1_err,
    output logic                       fpga_req,
    output logic                       fpga_wr_en,
    output logic                       fpga_rd_en,
    output logic [FPGA_ADDR_WIDTH-1:0] fpga_addr,
    output logic [FPGA_DATA_WIDTH-1:0] fpga_wr_data,
    input  logic                       fpga_ack,
    input  logic                       fpga_data_ready,
    input  logic [FPGA_DATA_WIDTH-1:0] fpga_rd_data,
    output logic                       grant
);

    localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 8) ? $clog2(RD_TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ISSUE        = 3'd1,
        WAIT_ACK_LOW = 3'd2,
        WAIT_DATA    = 3'd3,
        DONE         = 3'd4
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic                       grant_nx;
    logic                       any_req;
    logic                       wr_en_q;
    logic                       have_data;
    logic [FPGA_DATA_WIDTH-1:0] rd_buf;
    logic [CNT_W-1:0]           cnt;
    logic                       timeout;
    logic                       capture;
    logic [FPGA_DATA_WIDTH-1:0] res_data;
    logic                       res_err;

    assign any_req = m0_req | m1_req;
    // Counter is zero in the first WAIT_ACK_LOW cycle, so DONE lands RD_TIMEOUT cycles after entry
    assign timeout = (cnt == CNT_W'(RD_TIMEOUT - 1));
    // Early read data (even coincident with ack) is latched so it cannot be lost
    assign capture = fpga_data_ready && !wr_en_q && !have_data &&
                     ((state == ISSUE) || (state == WAIT_ACK_LOW) || (state == WAIT_DATA));

    assign m0_done = (state == DONE) && !grant;
    assign m1_done = (state == DONE) &&  grant;

    always_comb begin
        grant_nx = grant;
        if (m0_req && m1_req) grant_nx = ~grant;
        else if (m0_req)      grant_nx = 1'b0;
        else if (m1_req)      grant_nx = 1'b1;
    end

    always_comb begin
        state_nx   = state;
        fpga_req   = 1'b0;
        fpga_wr_en = 1'b0;
        fpga_rd_en = 1'b0;
        case (state)
            IDLE: if (any_req) state_nx = ISSUE;
            ISSUE: begin
                fpga_req   = 1'b1;
                fpga_wr_en = wr_en_q;
                fpga_rd_en = ~wr_en_q;
                if (fpga_ack) state_nx = WAIT_ACK_LOW;
            end
            WAIT_ACK_LOW: begin
                if (!wr_en_q && !have_data && !fpga_data_ready && timeout)
                    state_nx = DONE;
                else if (!fpga_ack)
                    state_nx = wr_en_q ? DONE : WAIT_DATA;
            end
            WAIT_DATA: if (have_data || fpga_data_ready || timeout) state_nx = DONE;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        res_data = '0;
        res_err  = 1'b0;
        if (!wr_en_q) begin
            if (have_data)            res_data = rd_buf;
            else if (fpga_data_ready) res_data = fpga_rd_data;
            else                      res_err  = 1'b1;
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            state        <= IDLE;
            grant        <= 1'b1;
            wr_en_q      <= 1'b0;
            fpga_addr    <= '0;
            fpga_wr_data <= '0;
            have_data    <= 1'b0;
            rd_buf       <= '0;
            cnt          <= '0;
            m0_rd_data   <= '0;
            m0_err       <= 1'b0;
            m1_rd_data   <= '0;
            m1_err       <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                grant        <= grant_nx;
                wr_en_q      <= grant_nx ? m1_wr_en   : m0_wr_en;
                fpga_addr    <= grant_nx ? m1_addr    : m0_addr;
                fpga_wr_data <= grant_nx ? m1_wr_data : m0_wr_data;
                have_data    <= 1'b0;
            end
            if (capture) begin
                have_data <= 1'b1;
                rd_buf    <= fpga_rd_data;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT_ACK_LOW || state == WAIT_DATA)
                cnt <= cnt + 1'b1;
            // Results update on DONE entry; writes clear err but leave rd_data as it was
            if (state != DONE && state_nx == DONE) begin
                if (!grant) begin
                    m0_err <= res_err;
                    if (!wr_en_q) m0_rd_data <= res_data;
                end else begin
                    m1_err <= res_err;
                    if (!wr_en_q) m1_rd_data <= res_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Brief    : Open-loop directed bench; a transaction-level timeline model
//             predicts every output cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int AW   = 23;
    localparam int DW   = 32;
    localparam int TO   = 255;
    localparam int NC   = 400;
    localparam int NEND = 340;

    logic          clk = 1'b0;
    logic          fpga_reset;
    logic          m0_req, m0_wr_en, m1_req, m1_wr_en;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_done, m1_done, m0_err, m1_err;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic          fpga_req, fpga_wr_en, fpga_rd_en;
    logic [AW-1:0] fpga_addr;
    logic [DW-1:0] fpga_wr_data;
    logic          fpga_ack, fpga_data_ready;
    logic [DW-1:0] fpga_rd_data;
    logic          grant;

    sdram_arbiter #(.FPGA_ADDR_WIDTH(AW), .FPGA_DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
        .fpga_clk(clk), .fpga_reset(fpga_reset),
        .m0_req(m0_req), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
        .m0_done(m0_done), .m0_rd_data(m0_rd_data), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
        .m1_done(m1_done), .m1_rd_data(m1_rd_data), .m1_err(m1_err),
        .fpga_req(fpga_req), .fpga_wr_en(fpga_wr_en), .fpga_rd_en(fpga_rd_en),
        .fpga_addr(fpga_addr), .fpga_wr_data(fpga_wr_data),
        .fpga_ack(fpga_ack), .fpga_data_ready(fpga_data_ready), .fpga_rd_data(fpga_rd_data),
        .grant(grant)
    );

    always #5 clk = ~clk;

    // Stimulus timeline, indexed by cycle
    bit          in_rst [NC];
    bit          in_req [2][NC];
    bit          in_wr  [2][NC];
    bit [AW-1:0] in_addr[2][NC];
    bit [DW-1:0] in_wd  [2][NC];
    bit          in_ack [NC];
    bit          in_dr  [NC];
    bit [DW-1:0] in_rdd [NC];

    // Expected-event timeline
    bit          ex_rst [NC];
    bit          ex_gupd[NC];
    bit          ex_gval[NC];
    bit          ex_req [NC];
    bit          ex_wr  [NC];
    bit [AW-1:0] ex_addr[NC];
    bit [DW-1:0] ex_wd  [NC];
    bit          ex_dn  [2][NC];
    bit          ex_dwr [NC];
    bit [DW-1:0] ex_drd [NC];
    bit          ex_derr[NC];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int w, input int a, input int b);
        for (int c = a; c <= b; c++) in_req[w][c] = 1'b1;
    endtask

    // One transaction: request seen by an idle arbiter in cycle r, ack rises
    // a cycles later for len cycles, optional data_ready pulse in cycle x.
    task automatic plan(input int w, input bit wr, input bit [AW-1:0] addr, input bit [DW-1:0] wd,
                        input int r, input int a, input int len, input bit hasx, input int x,
                        input bit [DW-1:0] rdat, input bit hold, input int abort, output int d);
        int ac;
        int l;
        int last;
        ac = r + a;
        l  = ac + len;
        for (int c = ac; c < l; c++) in_ack[c] = 1'b1;
        if (hasx) begin
            in_dr[x]  = 1'b1;
            in_rdd[x] = rdat;
        end
        if (wr)        d = l + 1;
        else if (hasx) d = ((x > l + 1) ? x : l + 1) + 1;
        else           d = ac + 1 + TO;
        last = (abort > 0) ? abort : d;
        for (int c = r; c <= last; c++) begin
            if (hold || c == r) in_req[w][c] = 1'b1;
            in_wr[w][c]   = wr;
            in_addr[w][c] = addr;
            in_wd[w][c]   = wd;
        end
        ex_gupd[r+1] = 1'b1;
        ex_gval[r+1] = (w == 1);
        for (int c = r + 1; c <= ac; c++) begin
            ex_req[c]  = 1'b1;
            ex_wr[c]   = wr;
            ex_addr[c] = addr;
            ex_wd[c]   = wd;
        end
        if (abort > 0) begin
            in_rst[abort]   = 1'b1;
            ex_rst[abort+1] = 1'b1;
            d = abort;
        end else begin
            ex_dn[w][d] = 1'b1;
            ex_dwr[d]   = wr;
            ex_drd[d]   = (wr || !hasx) ? '0 : rdat;
            ex_derr[d]  = !wr && !hasx;
        end
    endtask

    task automatic apply(input int c);
        fpga_reset      = in_rst[c];
        m0_req          = in_req[0][c];
        m0_wr_en        = in_wr[0][c];
        m0_addr         = in_addr[0][c];
        m0_wr_data      = in_wd[0][c];
        m1_req          = in_req[1][c];
        m1_wr_en        = in_wr[1][c];
        m1_addr         = in_addr[1][c];
        m1_wr_data      = in_wd[1][c];
        fpga_ack        = in_ack[c];
        fpga_data_ready = in_dr[c];
        fpga_rd_data    = in_rdd[c];
    endtask

    initial begin
        int d;
        for (int c = 0; c <= 2; c++) in_rst[c] = 1'b1;
        // Simultaneous requests after reset alternate m0, m1, m0, m1
        set_req(0, 5, 18);
        set_req(1, 5, 23);
        plan(0, 1, 23'h000100, 32'h11110000,  5, 1, 1, 0,  0, 32'h0,        1, 0, d); chk("model_rr0_done", d, 8);
        plan(1, 1, 23'h000200, 32'h22220000,  9, 2, 1, 0,  0, 32'h0,        1, 0, d); chk("model_rr1_done", d, 13);
        plan(0, 0, 23'h000300, 32'h0,        14, 1, 1, 1, 16, 32'h3333AAAA, 1, 0, d); chk("model_rr2_done", d, 18);
        plan(1, 0, 23'h000400, 32'h0,        19, 1, 1, 1, 22, 32'h4444BBBB, 1, 0, d); chk("model_rr3_done", d, 23);
        // Write with a stray data_ready mid-transaction
        plan(0, 1, 23'h3FF001, 32'h0000FF01, 25, 3, 1, 1, 27, 32'hDEAD0027, 1, 0, d); chk("model_wr_done", d, 30);
        plan(1, 0, 23'h2BE4F2, 32'h0,        32, 2, 2, 1, 40, 32'hF0F0FF02, 1, 0, d); chk("model_rd_done", d, 41);
        in_dr[43]  = 1'b1;
        in_rdd[43] = 32'hBAD00043;
        // Data coincident with ack
        plan(0, 0, 23'h001234, 32'h0,        45, 1, 3, 1, 46, 32'hA5A50038, 1, 0, d); chk("model_early_done", d, 51);
        plan(0, 0, 23'h0ABCDE, 32'h0,        53, 2, 1, 0,  0, 32'h0,        1, 0, d); chk("model_tmo_done", d, 311);
        // Requester drops req right after grant
        plan(1, 1, 23'h7FFFFF, 32'hCAFEF00D, 313, 1, 1, 0, 0, 32'h0,        0, 0, d); chk("model_drop_done", d, 316);
        plan(0, 0, 23'h055555, 32'h0,        318, 1, 1, 0, 0, 32'h0,        1, 326, d);
        plan(1, 0, 23'h012345, 32'h0,        329, 1, 1, 1, 332, 32'h13579BDF, 1, 0, d); chk("model_post_rst_done", d, 333);

        apply(0);
        while (cyc < NEND) begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            apply(cyc);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    bit          mg   = 1'b1;
    bit [DW-1:0] mrd[2];
    bit          merr[2];

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc <= NEND) begin
                if (ex_rst[cyc]) begin
                    mg = 1'b1;
                    for (int w = 0; w < 2; w++) begin
                        mrd[w]  = '0;
                        merr[w] = 1'b0;
                    end
                end
                if (ex_gupd[cyc]) mg = ex_gval[cyc];
                for (int w = 0; w < 2; w++) begin
                    if (ex_dn[w][cyc]) begin
                        merr[w] = ex_derr[cyc];
                        if (!ex_dwr[cyc]) mrd[w] = ex_drd[cyc];
                    end
                end
                chk("grant",      {31'b0, grant},      {31'b0, mg});
                chk("m0_done",    {31'b0, m0_done},    {31'b0, ex_dn[0][cyc]});
                chk("m1_done",    {31'b0, m1_done},    {31'b0, ex_dn[1][cyc]});
                chk("fpga_req",   {31'b0, fpga_req},   {31'b0, ex_req[cyc]});
                chk("fpga_wr_en", {31'b0, fpga_wr_en}, {31'b0, ex_req[cyc] &  ex_wr[cyc]});
                chk("fpga_rd_en", {31'b0, fpga_rd_en}, {31'b0, ex_req[cyc] & ~ex_wr[cyc]});
                chk("m0_rd_data", m0_rd_data, mrd[0]);
                chk("m0_err",     {31'b0, m0_err},     {31'b0, merr[0]});
                chk("m1_rd_data", m1_rd_data, mrd[1]);
                chk("m1_err",     {31'b0, m1_err},     {31'b0, merr[1]});
                if (ex_req[cyc]) begin
                    chk("fpga_addr",    {9'b0, fpga_addr}, {9'b0, ex_addr[cyc]});
                    chk("fpga_wr_data", fpga_wr_data,      ex_wd[cyc]);
                end
                case (cyc)
                    2:   chk("pin_reset_grant",  {31'b0, grant},      32'h1);
                    10:  chk("pin_rr_grant_m1",  {31'b0, grant},      32'h1);
                    15:  chk("pin_rr_grant_m0",  {31'b0, grant},      32'h0);
                    26:  chk("pin_wr_addr",      {9'b0, fpga_addr},   32'h003FF001);
                    28:  chk("pin_wr_en",        {31'b0, fpga_wr_en}, 32'h1);
                    29:  chk("pin_req_dropped",  {31'b0, fpga_req},   32'h0);
                    30:  chk("pin_wr_done",      {31'b0, m0_done},    32'h1);
                    41:  chk("pin_rd_data",      m1_rd_data,          32'hF0F0FF02);
                    51:  chk("pin_early_data",   m0_rd_data,          32'hA5A50038);
                    311: chk("pin_tmo_err",      {31'b0, m0_err},     32'h1);
                    327: chk("pin_rst_m1_data",  m1_rd_data,          32'h0);
                    333: chk("pin_post_rst_rd",  m1_rd_data,          32'h13579BDF);
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
